// File: rtl/dmem_seq.sv
// MEM-stage data-memory sequencer: req/ack bus handshake, byte enables, load extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses trap without a bus cycle.
module dmem_seq #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  dm_ctrl_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rdata_valid_o,
   output logic        err_o,
   output logic        misalign_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   // Undefined encodings (101..111) fall through to word size.
   function automatic logic is_byte(input logic [2:0] c);
      return (c == 3'b011) || (c == 3'b100);
   endfunction

   function automatic logic is_half(input logic [2:0] c);
      return (c == 3'b001) || (c == 3'b010);
   endfunction

   function automatic logic is_signed(input logic [2:0] c);
      return (c == 3'b001) || (c == 3'b011);
   endfunction

   logic [1:0]       state;
   logic             we_q;
   logic [2:0]       ctrl_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic [CNT_W-1:0] cnt;
   logic             err_q;
   logic             mis_q;

   logic             start;
   logic             mis_det;
   logic             in_req;
   logic [3:0]       be;
   logic [31:0]      lanes;
   logic [31:0]      load_ext;
   logic [7:0]       sel_b;
   logic [15:0]      sel_h;

   assign start  = mem_read_i | mem_write_i;
   assign in_req = (state == S_REQ);

`ifdef MISALIGN_TRAP_EN
   assign mis_det = (is_half(dm_ctrl_i) & addr_i[0]) |
                    (!is_half(dm_ctrl_i) & !is_byte(dm_ctrl_i) & (addr_i[1:0] != 2'b00));
`else
   assign mis_det = 1'b0;
`endif

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      be    = 4'b1111;
      lanes = wdata_q;
      if (is_byte(ctrl_q)) begin
         be    = 4'b0001 << addr_q[1:0];
         lanes = {4{wdata_q[7:0]}};
      end else if (is_half(ctrl_q)) begin
         be    = addr_q[1] ? 4'b1100 : 4'b0011;
         lanes = {2{wdata_q[15:0]}};
      end
   end

   always_comb begin
      sel_b    = bus_rdata_i[8*addr_q[1:0] +: 8];
      sel_h    = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      load_ext = bus_rdata_i;
      if (is_byte(ctrl_q)) begin
         load_ext = {{24{is_signed(ctrl_q) & sel_b[7]}}, sel_b};
      end else if (is_half(ctrl_q)) begin
         load_ext = {{16{is_signed(ctrl_q) & sel_h[15]}}, sel_h};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         ctrl_q  <= 3'b000;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt     <= '0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  we_q    <= mem_write_i;
                  ctrl_q  <= dm_ctrl_i;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  rdata_q <= '0;
                  cnt     <= '0;
                  err_q   <= mis_det;
                  mis_q   <= mis_det;
                  state   <= mis_det ? S_DONE : S_REQ;
               end
            end
            S_REQ: begin
               // Ack on the last counted cycle still completes normally.
               if (bus_ack_i) begin
                  rdata_q <= we_q ? '0 : load_ext;
                  state   <= S_DONE;
               end else if (cnt == CNT_LAST) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               cnt   <= '0;
               err_q <= 1'b0;
               mis_q <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign stall_o       = (state == S_IDLE) ? start : in_req;
   assign rdata_valid_o = (state == S_DONE);
   assign rdata_o       = rdata_q;
   assign err_o         = rdata_valid_o & err_q;
   assign misalign_o    = rdata_valid_o & mis_q;

   // Bus fields are gated so the bus is quiet outside a request.
   assign bus_req_o   = in_req;
   assign bus_we_o    = in_req & we_q;
   assign bus_addr_o  = in_req ? {addr_q[31:2], 2'b00} : '0;
   assign bus_be_o    = in_req ? be : 4'b0000;
   assign bus_wdata_o = in_req ? lanes : '0;

endmodule

// File: tb/tb_dmem_seq.sv
// Scoreboard bench for dmem_seq: driver pushes expectations, a bus responder and an
// output monitor pop and compare independently.
module tb_dmem_seq;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic        mem_read_i, mem_write_i;
   logic [2:0]  dm_ctrl_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_o, rdata_valid_o, err_o, misalign_o;
   logic [31:0] rdata_o;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
   logic [31:0] bus_rdata_i;

   always #5 clk = ~clk;

   dmem_seq #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk(clk), .rstn(rstn),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
      .dm_ctrl_i(dm_ctrl_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
      .err_o(err_o), .misalign_o(misalign_o),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
      .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
   );

   typedef struct {
      logic        chk_rdata;
      logic [31:0] rdata;
      logic        err;
      logic        mis;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   rsp_t        rsp_q[$];
   bus_t        bus_q[$];
   rsp_t        mon_e;
   bus_t        bus_e;
   int          total = 0;
   int          bad   = 0;
   int          ack_n = 0;
   logic [31:0] ack_data = '0;
   int          req_k = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   // Bus responder: acks in REQ cycle ack_n (0 = never), checks bus fields on the first cycle.
   initial begin
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (!rstn || !bus_req_o) begin
            req_k       = 0;
            bus_ack_i   = 1'b0;
            bus_rdata_i = '0;
         end else begin
            req_k++;
            if (req_k == 1) begin
               if (bus_q.size() == 0) begin
                  check("unexpected_req", 32'(bus_req_o), 32'd0);
               end else begin
                  bus_e = bus_q.pop_front();
                  check("bus_we",    32'(bus_we_o), 32'(bus_e.we));
                  check("bus_addr",  bus_addr_o,    bus_e.addr);
                  check("bus_be",    32'(bus_be_o), 32'(bus_e.be));
                  check("bus_wdata", bus_wdata_o,   bus_e.wdata);
               end
            end
            bus_ack_i   = (ack_n != 0) && (req_k == ack_n);
            bus_rdata_i = bus_ack_i ? ack_data : 32'h0;
         end
      end
   end

   // Output monitor: compares every completion against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rdata_valid_o) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_valid", 32'(rdata_valid_o), 32'd0);
            end else begin
               mon_e = rsp_q.pop_front();
               check("err",      32'(err_o),      32'(mon_e.err));
               check("misalign", 32'(misalign_o), 32'(mon_e.mis));
               if (mon_e.chk_rdata) check("rdata", rdata_o, mon_e.rdata);
            end
         end else if (err_o || misalign_o) begin
            check("stray_err", {30'd0, err_o, misalign_o}, 32'd0);
         end
      end
   end

   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input int n, input logic [31:0] data,
                         input logic has_bus, input bus_t b, input rsp_t r,
                         input int exp_stall, input int exp_req);
      int   stall_cnt;
      int   req_cnt;
      logic done;
      @(negedge clk);
      ack_n    = n;
      ack_data = data;
      if (has_bus) bus_q.push_back(b);
      rsp_q.push_back(r);
      mem_read_i  = rd;
      mem_write_i = wr;
      dm_ctrl_i   = ctrl;
      addr_i      = addr;
      wdata_i     = wdata;
      #1 check({tag, "_stall_comb"}, 32'(stall_o), 32'd1);
      stall_cnt = 1;
      req_cnt   = 0;
      done      = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 0) begin
            mem_read_i  = 1'b0;
            mem_write_i = 1'b0;
         end
         #1;
         if (!stall_o) begin
            done = 1'b1;
            break;
         end
         stall_cnt++;
         if (bus_req_o) req_cnt++;
      end
      if (!done) check({tag, "_complete"}, 32'd0, 32'd1);
      check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
      check({tag, "_req_cycles"},   req_cnt,   exp_req);
   endtask

   initial begin
      rstn        = 1'b0;
      mem_read_i  = 1'b0;
      mem_write_i = 1'b0;
      dm_ctrl_i   = 3'b000;
      addr_i      = '0;
      wdata_i     = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_stall",  32'(stall_o),       32'd0);
      check("rst_req",    32'(bus_req_o),     32'd0);
      check("rst_valid",  32'(rdata_valid_o), 32'd0);
      check("rst_err",    32'(err_o),         32'd0);
      check("rst_mis",    32'(misalign_o),    32'd0);
      check("rst_be",     32'(bus_be_o),      32'd0);
      check("rst_addr",   bus_addr_o,         32'd0);
      check("rst_rdata",  rdata_o,            32'd0);
      rstn = 1'b1;

      access("lw_ack3", 1, 0, 3'b000, 32'h100, 32'h0, 3, 32'hDEADBEEF,
             1, bus_t'{1'b0, 32'h100, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'hDEADBEEF, 1'b0, 1'b0}, 4, 3);
      access("lb_neg", 1, 0, 3'b011, 32'h103, 32'h0, 1, 32'h80FFFF7F,
             1, bus_t'{1'b0, 32'h100, 4'b1000, 32'h0}, rsp_t'{1'b1, 32'hFFFFFF80, 1'b0, 1'b0}, 2, 1);
      access("lbu", 1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80FFFF7F,
             1, bus_t'{1'b0, 32'h100, 4'b1000, 32'h0}, rsp_t'{1'b1, 32'h00000080, 1'b0, 1'b0}, 2, 1);
      access("lb_pos", 1, 0, 3'b011, 32'h101, 32'h0, 1, 32'h00007F00,
             1, bus_t'{1'b0, 32'h100, 4'b0010, 32'h0}, rsp_t'{1'b1, 32'h0000007F, 1'b0, 1'b0}, 2, 1);
      access("lh_hi", 1, 0, 3'b001, 32'h102, 32'h0, 2, 32'h80017FFF,
             1, bus_t'{1'b0, 32'h100, 4'b1100, 32'h0}, rsp_t'{1'b1, 32'hFFFF8001, 1'b0, 1'b0}, 3, 2);
      access("lhu_lo", 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'h1234F00D,
             1, bus_t'{1'b0, 32'h100, 4'b0011, 32'h0}, rsp_t'{1'b1, 32'h0000F00D, 1'b0, 1'b0}, 2, 1);
      access("sh", 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'h0,
             1, bus_t'{1'b1, 32'h200, 4'b1100, 32'hABCDABCD}, rsp_t'{1'b0, 32'h0, 1'b0, 1'b0}, 3, 2);
      access("sb", 0, 1, 3'b011, 32'h201, 32'h00000055, 1, 32'h0,
             1, bus_t'{1'b1, 32'h200, 4'b0010, 32'h55555555}, rsp_t'{1'b0, 32'h0, 1'b0, 1'b0}, 2, 1);
      access("lw_timeout", 1, 0, 3'b000, 32'h300, 32'h0, 0, 32'h0,
             1, bus_t'{1'b0, 32'h300, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'h0, 1'b1, 1'b0}, 5, 4);
      access("lw_after_to", 1, 0, 3'b000, 32'h104, 32'h0, 1, 32'h0BADF00D,
             1, bus_t'{1'b0, 32'h104, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'h0BADF00D, 1'b0, 1'b0}, 2, 1);
      access("lw_ack_last", 1, 0, 3'b000, 32'h108, 32'h0, TO, 32'hCAFEF00D,
             1, bus_t'{1'b0, 32'h108, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'hCAFEF00D, 1'b0, 1'b0}, 5, 4);
      access("rd_wr_both", 1, 1, 3'b000, 32'h010, 32'hA5A55A5A, 1, 32'h0,
             1, bus_t'{1'b1, 32'h010, 4'b1111, 32'hA5A55A5A}, rsp_t'{1'b0, 32'h0, 1'b0, 1'b0}, 2, 1);
      access("ctrl_undef", 1, 0, 3'b111, 32'h020, 32'h0, 1, 32'h11223344,
             1, bus_t'{1'b0, 32'h020, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'h11223344, 1'b0, 1'b0}, 2, 1);
`ifdef MISALIGN_TRAP_EN
      access("lw_misalign", 1, 0, 3'b000, 32'h102, 32'h0, 1, 32'h76543210,
             0, bus_t'{1'b0, 32'h0, 4'b0000, 32'h0}, rsp_t'{1'b1, 32'h0, 1'b1, 1'b1}, 1, 0);
`else
      access("lw_misalign", 1, 0, 3'b000, 32'h102, 32'h0, 1, 32'h76543210,
             1, bus_t'{1'b0, 32'h100, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'h76543210, 1'b0, 1'b0}, 2, 1);
`endif

      // Asynchronous reset in the middle of a bus request.
      @(negedge clk);
      ack_n = 0;
      bus_q.push_back(bus_t'{1'b0, 32'h400, 4'b1111, 32'h0});
      mem_read_i = 1'b1;
      dm_ctrl_i  = 3'b000;
      addr_i     = 32'h400;
      @(negedge clk);
      mem_read_i = 1'b0;
      #1 check("arst_req_before", 32'(bus_req_o), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst_req",   32'(bus_req_o),     32'd0);
      check("arst_stall", 32'(stall_o),       32'd0);
      check("arst_valid", 32'(rdata_valid_o), 32'd0);
      check("arst_be",    32'(bus_be_o),      32'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      #1;
      check("post_rst_stall", 32'(stall_o),   32'd0);
      check("post_rst_req",   32'(bus_req_o), 32'd0);

      access("lw_post_rst", 1, 0, 3'b000, 32'h500, 32'h0, 2, 32'h600DF00D,
             1, bus_t'{1'b0, 32'h500, 4'b1111, 32'h0}, rsp_t'{1'b1, 32'h600DF00D, 1'b0, 1'b0}, 3, 2);

      repeat (3) @(negedge clk);
      #1;
      check("rsp_q_drained", rsp_q.size(), 32'd0);
      check("bus_q_drained", bus_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
